prt_tx_drain: RTL

- Read-side client of the packet reference table (PRT). Consumes per-packet verdicts (slot + allow/drop) from the classifier.
- Allowed packets: drives the PRT start-read/read method handshakes and streams bytes out on a valid/ready egress interface, then invalidates the slot.
- Dropped packets: invalidates the slot without reading it.
- Sits between the PRT and the egress MAC/TX FIFO.

---
 rtl/prt_pkg.sv | 22 ++
 rtl/prt_tx_outreg.sv | 37 +++
 rtl/prt_tx_drain.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/prt_pkg.sv
// Shared constants, PRT read-word layout and TX drain FSM states for the PRT read side.
package prt_pkg;

    localparam int unsigned PRT_SLOT_W        = 1;
    localparam int unsigned PRT_DATA_W        = 8;
    localparam int unsigned PRT_MAX_PKT_BYTES = 1518;
    localparam int unsigned PRT_CNT_W         = 11;

    typedef struct packed {
        logic                  last;
        logic [PRT_DATA_W-1:0] data;
    } prt_word_t;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StStream,
        StFlush,
        StInval
    } tx_state_e;

endpackage

// File: rtl/prt_tx_outreg.sv
// Single-entry egress holding register; accepts a new byte whenever empty or draining.
module prt_tx_outreg
    import prt_pkg::*;
#(
    parameter int unsigned DATA_W = PRT_DATA_W
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    input  logic              tx_ready,
    output logic              can_load,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_last,
    output logic              tx_valid
);

    // Combinational from tx_ready so a full register refills in the cycle it drains.
    assign can_load = !tx_valid || tx_ready;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tx_valid <= 1'b0;
            tx_last  <= 1'b0;
            tx_data  <= '0;
        end else if (load) begin
            tx_valid <= 1'b1;
            tx_last  <= load_last;
            tx_data  <= load_data;
        end else if (tx_valid && tx_ready) begin
            tx_valid <= 1'b0;
            tx_last  <= 1'b0;
        end
    end

endmodule

// File: rtl/prt_tx_drain.sv
// PRT read-side client: streams allowed packets to egress, then frees the slot.
// Optional packet statistics are built when PRT_TX_STATS_EN is defined.
module prt_tx_drain
    import prt_pkg::*;
#(
    parameter int unsigned SLOT_W        = PRT_SLOT_W,
    parameter int unsigned DATA_W        = PRT_DATA_W,
    parameter int unsigned MAX_PKT_BYTES = PRT_MAX_PKT_BYTES,
    parameter int unsigned CNT_W         = PRT_CNT_W
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              verdict_valid,
    input  logic [SLOT_W-1:0] verdict_slot,
    input  logic              verdict_allow,
    output logic              verdict_ready,
    output logic              EN_start_reading_prt_entry,
    output logic [SLOT_W-1:0] start_reading_prt_entry_slot,
    input  logic              RDY_start_reading_prt_entry,
    output logic              EN_read_prt_entry,
    input  logic [DATA_W:0]   read_prt_entry,
    input  logic              RDY_read_prt_entry,
    output logic              EN_invalidate_prt_entry,
    output logic [SLOT_W-1:0] invalidate_prt_entry_slot,
    input  logic              RDY_invalidate_prt_entry,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_last,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              err_oversize
`ifdef PRT_TX_STATS_EN
    ,
    output logic [31:0]       tx_pkt_count,
    output logic [31:0]       drop_pkt_count
`endif
);

    tx_state_e         state_q;
    logic [SLOT_W-1:0] slot_q;
    logic              allow_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              err_q;

    logic              can_load;
    logic              rd_flag;
    logic              at_limit;
    logic              load_last;
    logic              verdict_fire;

    assign rd_flag   = read_prt_entry[DATA_W];
    assign at_limit  = (cnt_q == CNT_W'(MAX_PKT_BYTES - 1));
    assign load_last = rd_flag || at_limit;

    assign verdict_ready = (state_q == StIdle);
    assign verdict_fire  = verdict_ready && verdict_valid;

    assign EN_start_reading_prt_entry = (state_q == StStart) && allow_q &&
                                        RDY_start_reading_prt_entry;
    assign EN_read_prt_entry          = (state_q == StStream) && RDY_read_prt_entry && can_load;
    assign EN_invalidate_prt_entry    = (state_q == StInval) && RDY_invalidate_prt_entry;

    assign start_reading_prt_entry_slot = slot_q;
    assign invalidate_prt_entry_slot    = slot_q;
    assign err_oversize                 = err_q;

    prt_tx_outreg #(
        .DATA_W (DATA_W)
    ) u_outreg (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .load      (EN_read_prt_entry),
        .load_data (read_prt_entry[DATA_W-1:0]),
        .load_last (load_last),
        .tx_ready  (tx_ready),
        .can_load  (can_load),
        .tx_data   (tx_data),
        .tx_last   (tx_last),
        .tx_valid  (tx_valid)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= StIdle;
            slot_q  <= '0;
            allow_q <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (verdict_valid) begin
                        slot_q  <= verdict_slot;
                        allow_q <= verdict_allow;
                        state_q <= verdict_allow ? StStart : StInval;
                    end
                end
                StStart: begin
                    if (EN_start_reading_prt_entry) begin
                        cnt_q   <= '0;
                        state_q <= StStream;
                    end
                end
                StStream: begin
                    if (EN_read_prt_entry) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (load_last) begin
                            state_q <= StFlush;
                        end
                        // Limit-forced last: the unread tail is freed by the invalidate.
                        if (at_limit && !rd_flag) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                StFlush: begin
                    if (tx_valid && tx_ready) begin
                        state_q <= StInval;
                    end
                end
                StInval: begin
                    if (EN_invalidate_prt_entry) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef PRT_TX_STATS_EN
    logic [31:0] tx_pkt_count_q;
    logic [31:0] drop_pkt_count_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tx_pkt_count_q   <= '0;
            drop_pkt_count_q <= '0;
        end else begin
            if (tx_valid && tx_ready && tx_last) begin
                tx_pkt_count_q <= tx_pkt_count_q + 32'd1;
            end
            if (verdict_fire && !verdict_allow) begin
                drop_pkt_count_q <= drop_pkt_count_q + 32'd1;
            end
        end
    end

    assign tx_pkt_count   = tx_pkt_count_q;
    assign drop_pkt_count = drop_pkt_count_q;
`else
    logic unused_fire;
    assign unused_fire = verdict_fire;
`endif

endmodule
